usb_buffer_arbiter: RTL and testbench



---
 rtl/usb_buffer_pkg.sv | 18 +
 rtl/packet_buffer_ram.sv | 36 +++
 rtl/usb_buffer_arbiter.sv | 150 +++++++++++++++
 tb/tb_usb_buffer_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared types and helpers for the USB packet-buffer arbiter.
// Grant encoding, streak counter width and CPU section-to-lane mapping.
package usb_buffer_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_USB  = 2'd1,
        GRANT_CPU  = 2'd2
    } grant_t;

    localparam int STREAK_WIDTH = 2;

    // bit0 = byte0, bit1 = byte1, bit2 = bytes 2-3
    function automatic logic [3:0] sections_to_byte_enables(input logic [2:0] sections);
        return {sections[2], sections[2], sections[1], sections[0]};
    endfunction

endpackage

// File: rtl/packet_buffer_ram.sv
// Single-port packet buffer: DEPTH_WORDS x 32 bits, per-byte write enables,
// registered read data available the cycle after the access.
module packet_buffer_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk48,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // NOTE: the storage array has no reset so it maps onto a RAM macro; contents survive reset.
    always_ff @(posedge clk48) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Shares the single-port USB packet buffer between CPU word accesses and USB byte
// streaming; USB has priority, bounded by a starvation guard for the CPU.
module usb_buffer_arbiter
    import usb_buffer_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk48,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [7:0]  cpu_address,
    input  logic [2:0]  cpu_write_sections,
    input  logic [31:0] cpu_write_value,
    output logic        cpu_ack,
    output logic        cpu_read_valid,
    output logic [31:0] cpu_read_value,

    input  logic        usb_req,
    input  logic        usb_write,
    input  logic [9:0]  usb_address,
    input  logic [7:0]  usb_write_byte,
    output logic        usb_ack,
    output logic        usb_read_valid,
    output logic [7:0]  usb_read_byte
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    grant_t                  w_grant;
    logic [STREAK_WIDTH-1:0] r_streak;
    logic                    w_streak_at_limit;
    logic                    w_cpu_is_write;

    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [3:0]              w_ram_be;
    logic [ADDR_W-1:0]       w_ram_addr;
    logic [31:0]             w_ram_wdata;
    logic [31:0]             w_ram_rdata;

    logic                    r_cpu_rd_valid;
    logic                    r_usb_rd_valid;
    logic [1:0]              r_usb_lane;
    logic [31:0]             r_cpu_hold;
    logic [7:0]              r_usb_hold;
    logic [7:0]              w_usb_lane_byte;

    assign w_streak_at_limit = (r_streak == STREAK_WIDTH'(STARVE_LIMIT));
    assign w_cpu_is_write    = |cpu_write_sections;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!reset) begin
            if (usb_req && cpu_req) begin
                w_grant = w_streak_at_limit ? GRANT_CPU : GRANT_USB;
            end else if (usb_req) begin
                w_grant = GRANT_USB;
            end else if (cpu_req) begin
                w_grant = GRANT_CPU;
            end
        end
    end

    assign cpu_ack = (w_grant == GRANT_CPU);
    assign usb_ack = (w_grant == GRANT_USB);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!cpu_req || w_grant == GRANT_CPU) begin
            r_streak <= '0;
        end else if (w_grant == GRANT_USB && r_streak != '1) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'b0000;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        case (w_grant)
            GRANT_CPU: begin
                w_ram_en    = 1'b1;
                w_ram_we    = w_cpu_is_write;
                w_ram_be    = sections_to_byte_enables(cpu_write_sections);
                w_ram_addr  = cpu_address[ADDR_W-1:0];
                w_ram_wdata = cpu_write_value;
            end
            GRANT_USB: begin
                w_ram_en    = 1'b1;
                w_ram_we    = usb_write;
                w_ram_be    = usb_write ? (4'b0001 << usb_address[1:0]) : 4'b0000;
                w_ram_addr  = usb_address[ADDR_W+1:2];
                w_ram_wdata = {4{usb_write_byte}};
            end
            default: begin
            end
        endcase
    end

    packet_buffer_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk48   (clk48),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_usb_lane_byte = w_ram_rdata[{r_usb_lane, 3'b000} +: 8];

    always_ff @(posedge clk48) begin
        if (reset) begin
            r_cpu_rd_valid <= 1'b0;
            r_usb_rd_valid <= 1'b0;
            r_usb_lane     <= 2'b00;
            r_cpu_hold     <= '0;
            r_usb_hold     <= '0;
        end else begin
            r_cpu_rd_valid <= (w_grant == GRANT_CPU) && !w_cpu_is_write;
            r_usb_rd_valid <= (w_grant == GRANT_USB) && !usb_write;
            if (w_grant == GRANT_USB && !usb_write) begin
                r_usb_lane <= usb_address[1:0];
            end
            if (r_cpu_rd_valid) begin
                r_cpu_hold <= w_ram_rdata;
            end
            if (r_usb_rd_valid) begin
                r_usb_hold <= w_usb_lane_byte;
            end
        end
    end

    // Read outputs are gated by reset so a reset right after a read ack hides that result at once.
    assign cpu_read_valid = r_cpu_rd_valid && !reset;
    assign cpu_read_value = reset ? '0 : (r_cpu_rd_valid ? w_ram_rdata : r_cpu_hold);
    assign usb_read_valid = r_usb_rd_valid && !reset;
    assign usb_read_byte  = reset ? '0 : (r_usb_rd_valid ? w_usb_lane_byte : r_usb_hold);

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Self-checking bench for usb_buffer_arbiter: directed scenarios followed by
// randomized traffic checked against a byte-array memory and wait-count model.
module tb_usb_buffer_arbiter;

    localparam int STARVE_LIMIT = 2;

    logic        clk48;
    logic        reset;
    logic        cpu_req;
    logic [7:0]  cpu_address;
    logic [2:0]  cpu_write_sections;
    logic [31:0] cpu_write_value;
    logic        cpu_ack;
    logic        cpu_read_valid;
    logic [31:0] cpu_read_value;
    logic        usb_req;
    logic        usb_write;
    logic [9:0]  usb_address;
    logic [7:0]  usb_write_byte;
    logic        usb_ack;
    logic        usb_read_valid;
    logic [7:0]  usb_read_byte;

    usb_buffer_arbiter #(
        .DEPTH_WORDS  (256),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk48              (clk48),
        .reset              (reset),
        .cpu_req            (cpu_req),
        .cpu_address        (cpu_address),
        .cpu_write_sections (cpu_write_sections),
        .cpu_write_value    (cpu_write_value),
        .cpu_ack            (cpu_ack),
        .cpu_read_valid     (cpu_read_valid),
        .cpu_read_value     (cpu_read_value),
        .usb_req            (usb_req),
        .usb_write          (usb_write),
        .usb_address        (usb_address),
        .usb_write_byte     (usb_write_byte),
        .usb_ack            (usb_ack),
        .usb_read_valid     (usb_read_valid),
        .usb_read_byte      (usb_read_byte)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_mem [1024];
    logic [31:0] last_cpu_rd;
    logic [7:0]  last_usb_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk48) begin
        assert (!(cpu_ack && usb_ack))
        else begin
            n_fail++;
            $display("FAIL ack_mutex: both acks high at %0t", $time);
        end
    end

    function automatic logic [31:0] model_word(input int w);
        return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
    endfunction

    task automatic model_cpu_write(input int w, input logic [2:0] s, input logic [31:0] v);
        if (s[0]) m_mem[4*w]   = v[7:0];
        if (s[1]) m_mem[4*w+1] = v[15:8];
        if (s[2]) begin
            m_mem[4*w+2] = v[23:16];
            m_mem[4*w+3] = v[31:24];
        end
    endtask

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    // Entered and left just after a rising edge; the request is uncontested.
    task automatic cpu_op(input string tag, input logic [7:0] a, input logic [2:0] s,
                          input logic [31:0] v);
        int lat;
        logic [31:0] exp;
        lat = -1;
        exp = '0;
        cpu_req = 1'b1;
        cpu_address = a;
        cpu_write_sections = s;
        cpu_write_value = v;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk48);
            if (cpu_ack) begin
                lat = i;
                break;
            end
        end
        check({tag, "_ack_latency"}, 32'(lat), 32'd0);
        if (s == 3'd0) exp = model_word(int'(a));
        else model_cpu_write(int'(a), s, v);
        tick();
        cpu_req = 1'b0;
        @(negedge clk48);
        check({tag, "_read_valid"}, 32'(cpu_read_valid), 32'(s == 3'd0));
        if (s == 3'd0) begin
            check({tag, "_read_value"}, cpu_read_value, exp);
            last_cpu_rd = exp;
        end
        tick();
    endtask

    task automatic usb_op(input string tag, input logic wr, input logic [9:0] a,
                          input logic [7:0] d);
        int lat;
        logic [7:0] exp;
        lat = -1;
        exp = '0;
        usb_req = 1'b1;
        usb_write = wr;
        usb_address = a;
        usb_write_byte = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk48);
            if (usb_ack) begin
                lat = i;
                break;
            end
        end
        check({tag, "_ack_latency"}, 32'(lat), 32'd0);
        if (wr) m_mem[int'(a)] = d;
        else exp = m_mem[int'(a)];
        tick();
        usb_req = 1'b0;
        @(negedge clk48);
        check({tag, "_read_valid"}, 32'(usb_read_valid), 32'(!wr));
        if (!wr) begin
            check({tag, "_read_byte"}, 32'(usb_read_byte), 32'(exp));
            last_usb_rd = exp;
        end
        tick();
    endtask

    initial begin
        bit          cpu_pend, usb_pend, cpu_g, usb_g;
        bit          exp_crv, exp_urv;
        int          cpu_wait;
        logic [31:0] exp_cval;
        logic [7:0]  exp_uval;

        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_address = '0;
        cpu_write_sections = '0;
        cpu_write_value = '0;
        usb_req = 1'b0;
        usb_write = 1'b0;
        usb_address = '0;
        usb_write_byte = '0;
        last_cpu_rd = '0;
        last_usb_rd = '0;

        // Reset state, with both requests raised during reset
        tick();
        tick();
        cpu_req = 1'b1;
        usb_req = 1'b1;
        @(negedge clk48);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_usb_ack", 32'(usb_ack), 32'd0);
        check("rst_cpu_rv", 32'(cpu_read_valid), 32'd0);
        check("rst_usb_rv", 32'(usb_read_valid), 32'd0);
        check("rst_cpu_val", cpu_read_value, 32'd0);
        check("rst_usb_val", 32'(usb_read_byte), 32'd0);
        check("rst_streak", 32'(dut.r_streak), 32'd0);
        tick();
        cpu_req = 1'b0;
        usb_req = 1'b0;
        reset = 1'b0;

        // CPU-only word path
        cpu_op("cpu_wr_full", 8'd5, 3'b111, 32'hDEADBEEF);
        cpu_op("cpu_rd_full", 8'd5, 3'b000, 32'h0);
        cpu_op("cpu_wr_part", 8'd5, 3'b010, 32'h0000AA00);
        cpu_op("cpu_rd_part", 8'd5, 3'b000, 32'h0);

        // USB byte path
        usb_op("usb_wr0", 1'b1, 10'h010, 8'h11);
        usb_op("usb_wr1", 1'b1, 10'h011, 8'h22);
        usb_op("usb_wr2", 1'b1, 10'h012, 8'h33);
        usb_op("usb_wr3", 1'b1, 10'h013, 8'h44);
        cpu_op("cpu_rd_w4", 8'd4, 3'b000, 32'h0);
        usb_op("usb_rd12", 1'b0, 10'h012, 8'h00);

        // Contention: USB held, CPU raised in cycle 0
        usb_req = 1'b1;
        usb_write = 1'b0;
        usb_address = 10'h012;
        cpu_req = 1'b1;
        cpu_address = 8'd4;
        cpu_write_sections = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk48);
            check($sformatf("cont_usb_ack_c%0d", c), 32'(usb_ack), 32'(c < STARVE_LIMIT));
            check($sformatf("cont_cpu_ack_c%0d", c), 32'(cpu_ack), 32'(c == STARVE_LIMIT));
            if (c == 1) begin
                check("cont_usb_rv_c1", 32'(usb_read_valid), 32'd1);
                check("cont_usb_byte_c1", 32'(usb_read_byte), 32'(m_mem[32'h12]));
            end
            tick();
        end
        cpu_req = 1'b0;
        @(negedge clk48);
        check("cont_usb_ack_c3", 32'(usb_ack), 32'd1);
        check("cont_cpu_rv_c3", 32'(cpu_read_valid), 32'd1);
        check("cont_cpu_val_c3", cpu_read_value, model_word(4));
        check("cont_streak_c3", 32'(dut.r_streak), 32'd0);
        tick();
        usb_req = 1'b0;

        // Reset in the cycle after a CPU read ack
        cpu_req = 1'b1;
        cpu_address = 8'd4;
        cpu_write_sections = 3'b000;
        @(negedge clk48);
        check("rstrd_ack", 32'(cpu_ack), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk48);
        check("rstrd_rv", 32'(cpu_read_valid), 32'd0);
        check("rstrd_val", cpu_read_value, 32'd0);
        check("rstrd_no_ack0", 32'(cpu_ack), 32'd0);
        check("rstrd_usb_val", 32'(usb_read_byte), 32'd0);
        tick();
        @(negedge clk48);
        check("rstrd_no_ack1", 32'(cpu_ack), 32'd0);
        check("rstrd_val_hold", cpu_read_value, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk48);
        check("rstrd_ack_after", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 1'b0;
        @(negedge clk48);
        check("rstrd_rv_after", 32'(cpu_read_valid), 32'd1);
        check("rstrd_val_after", cpu_read_value, model_word(4));
        last_cpu_rd = model_word(4);
        last_usb_rd = 8'h00;
        tick();

        // Fill the random working set (words 0..15) with known data
        for (int w = 0; w < 16; w++) begin
            cpu_op("fill", 8'(w), 3'b111, $urandom);
        end

        // Randomized traffic against the reference model
        cpu_pend = 0;
        usb_pend = 0;
        cpu_wait = 0;
        exp_crv = 0;
        exp_urv = 0;
        exp_cval = '0;
        exp_uval = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!cpu_pend) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_pend = 1;
                    cpu_req = 1'b1;
                    cpu_address = 8'($urandom_range(0, 15));
                    cpu_write_sections = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 7));
                    cpu_write_value = $urandom;
                end else begin
                    cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_pend = 0;
                cpu_req = 1'b0;
            end
            if (!usb_pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    usb_pend = 1;
                    usb_req = 1'b1;
                    usb_write = 1'($urandom_range(0, 1));
                    usb_address = 10'($urandom_range(0, 63));
                    usb_write_byte = 8'($urandom);
                end else begin
                    usb_req = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                usb_pend = 0;
                usb_req = 1'b0;
            end

            @(negedge clk48);
            check("rnd_cpu_rv", 32'(cpu_read_valid), 32'(exp_crv));
            check("rnd_cpu_val", cpu_read_value, exp_crv ? exp_cval : last_cpu_rd);
            if (exp_crv) last_cpu_rd = exp_cval;
            check("rnd_usb_rv", 32'(usb_read_valid), 32'(exp_urv));
            check("rnd_usb_val", 32'(usb_read_byte), 32'(exp_urv ? exp_uval : last_usb_rd));
            if (exp_urv) last_usb_rd = exp_uval;

            // USB first, except once the CPU has already waited STARVE_LIMIT cycles
            if (cpu_req && usb_req) cpu_g = (cpu_wait >= STARVE_LIMIT);
            else cpu_g = cpu_req;
            usb_g = usb_req && !cpu_g;
            check("rnd_cpu_ack", 32'(cpu_ack), 32'(cpu_g));
            check("rnd_usb_ack", 32'(usb_ack), 32'(usb_g));

            exp_crv = 0;
            exp_urv = 0;
            if (cpu_g) begin
                if (cpu_write_sections == 3'd0) begin
                    exp_crv = 1;
                    exp_cval = model_word(int'(cpu_address));
                end else begin
                    model_cpu_write(int'(cpu_address), cpu_write_sections, cpu_write_value);
                end
                cpu_pend = 0;
                cpu_wait = 0;
            end else if (cpu_req) begin
                cpu_wait++;
            end else begin
                cpu_wait = 0;
            end
            if (usb_g) begin
                if (usb_write) m_mem[int'(usb_address)] = usb_write_byte;
                else begin
                    exp_urv = 1;
                    exp_uval = m_mem[int'(usb_address)];
                end
                usb_pend = 0;
            end
            tick();
        end
        cpu_req = 1'b0;
        usb_req = 1'b0;
        @(negedge clk48);
        check("drain_cpu_rv", 32'(cpu_read_valid), 32'(exp_crv));
        if (exp_crv) check("drain_cpu_val", cpu_read_value, exp_cval);
        check("drain_usb_rv", 32'(usb_read_valid), 32'(exp_urv));
        if (exp_urv) check("drain_usb_val", 32'(usb_read_byte), 32'(exp_uval));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
